// File: rtl/q_4d_share_divider.sv
// Shared signed fixed-point divider: (dividend<<FRAC_BITS)/dividor, saturated, one restoring bit per clock.
// Latency: done high after edge E0+N+3 (E0+N+4 with DIV_ROUND_EN, which adds a guard bit and half-away-from-zero rounding).
// Backpressure: none; division_start is only sampled in IDLE and is dropped otherwise.
module q_4d_share_divider #(
    parameter int DIVIDEND_WIDTH = 12,
    parameter int DIVIDOR_WIDTH  = 12,
    parameter int QUOTIENT_WIDTH = 9,
    parameter int FRAC_BITS      = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVIDOR_WIDTH-1:0]  dividor,
    input  logic                      division_start,
    output logic [QUOTIENT_WIDTH-1:0] signed_division,
    output logic                      division_done,
    output logic                      div_busy,
    output logic                      div_by_zero,
    output logic                      div_ovf
);

    localparam int N = DIVIDEND_WIDTH + FRAC_BITS;
`ifdef DIV_ROUND_EN
    localparam int CB = N + 1;
`else
    localparam int CB = N;
`endif
    localparam int MAGA_W = DIVIDEND_WIDTH + 1;
    localparam int REM_W  = DIVIDOR_WIDTH + 1;
    localparam int SH     = CB - DIVIDEND_WIDTH;
    localparam int QW     = QUOTIENT_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_SIGN = 2'd3;

    localparam logic [4:0]    CNT_INIT = 5'(CB - 1);
    localparam logic [CB-1:0] MAG_MAX  = CB'((1 << (QW - 1)) - 1);
    localparam logic [CB-1:0] MAG_MIN  = CB'(1 << (QW - 1));
    localparam logic [QW-1:0] POS_SAT  = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] NEG_SAT  = {1'b1, {(QW-1){1'b0}}};

    logic [1:0]                state_q, state_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIVIDOR_WIDTH-1:0]  dvr_q, dvr_d;
    logic [CB-1:0]             num_q, num_d;
    logic [REM_W-1:0]          rem_q, rem_d;
    logic [REM_W-1:0]          dvs_q, dvs_d;
    logic [4:0]                cnt_q, cnt_d;
    logic                      sign_q, sign_d;
    logic                      zero_q, zero_d;
    logic                      dneg_q, dneg_d;
    logic                      pend_q, pend_d;
    logic                      done_q, done_d;
    logic [QW-1:0]             res_q, res_d;
    logic                      dbz_q, dbz_d;
    logic                      ovf_q, ovf_d;

    logic [MAGA_W-1:0] dvd_ext, mag_a;
    logic [REM_W-1:0]  dvr_ext, mag_b;
    logic [REM_W:0]    trial, dvs_ext, diff;
    logic              ge;
    logic [CB-1:0]     mag;
    logic [QW-1:0]     fin_res;
    logic              fin_dbz, fin_ovf;

    // Magnitudes are one bit wider than the operands so the most negative value stays exact.
    assign dvd_ext = {dvd_q[DIVIDEND_WIDTH-1], dvd_q};
    assign mag_a   = dvd_q[DIVIDEND_WIDTH-1] ? (~dvd_ext + 1'b1) : dvd_ext;
    assign dvr_ext = {dvr_q[DIVIDOR_WIDTH-1], dvr_q};
    assign mag_b   = dvr_q[DIVIDOR_WIDTH-1] ? (~dvr_ext + 1'b1) : dvr_ext;

    assign trial   = {rem_q, num_q[CB-1]};
    assign dvs_ext = {1'b0, dvs_q};
    assign ge      = (trial >= dvs_ext);
    assign diff    = trial - dvs_ext;

`ifdef DIV_ROUND_EN
    assign mag = {1'b0, num_q[CB-1:1]} + CB'(num_q[0]);
`else
    assign mag = num_q;
`endif

    always_comb begin
        fin_res = sign_q ? (~mag[QW-1:0] + 1'b1) : mag[QW-1:0];
        fin_dbz = 1'b0;
        fin_ovf = 1'b0;
        if (zero_q) begin
            fin_res = dneg_q ? NEG_SAT : POS_SAT;
            fin_dbz = 1'b1;
        end else if (!sign_q && (mag > MAG_MAX)) begin
            fin_res = POS_SAT;
            fin_ovf = 1'b1;
        end else if (sign_q && (mag > MAG_MIN)) begin
            fin_res = NEG_SAT;
            fin_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvr_d   = dvr_q;
        num_d   = num_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        dneg_d  = dneg_q;
        pend_d  = (state_q == S_SIGN);
        done_d  = pend_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (division_start) begin
                    dvd_d   = dividend;
                    dvr_d   = dividor;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                num_d   = {{(CB-MAGA_W){1'b0}}, mag_a} << SH;
                dvs_d   = mag_b;
                rem_d   = '0;
                sign_d  = dvd_q[DIVIDEND_WIDTH-1] ^ dvr_q[DIVIDOR_WIDTH-1];
                zero_d  = (dvr_q == '0);
                dneg_d  = dvd_q[DIVIDEND_WIDTH-1];
                cnt_d   = CNT_INIT;
                state_d = S_CALC;
            end
            S_CALC: begin
                // Numerator bits shift out the top while quotient bits fill in from the bottom.
                rem_d = ge ? diff[REM_W-1:0] : trial[REM_W-1:0];
                num_d = {num_q[CB-2:0], ge};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_SIGN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Quotient registers stay untouched until the next LOAD, so the commit one cycle later is safe.
        if (pend_q) begin
            res_d = fin_res;
            dbz_d = fin_dbz;
            ovf_d = fin_ovf;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvr_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            dneg_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvr_q   <= dvr_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            dneg_q  <= dneg_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign signed_division = res_q;
    assign division_done   = done_q;
    assign div_busy        = (state_q != S_IDLE);
    assign div_by_zero     = dbz_q;
    assign div_ovf         = ovf_q;

endmodule

// File: tb/tb_q_4d_share_divider.sv
// Scoreboard bench for q_4d_share_divider: directed corner vectors, random vectors, and control cases.
module tb_q_4d_share_divider;

    localparam int N = 20;
`ifdef DIV_ROUND_EN
    localparam int LAT = N + 4;
    localparam logic [8:0] R_2_3 = 9'h0AB;
`else
    localparam int LAT = N + 3;
    localparam logic [8:0] R_2_3 = 9'h0AA;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] dividend = '0;
    logic [11:0] dividor = '0;
    logic        division_start = 1'b0;
    logic [8:0]  signed_division;
    logic        division_done;
    logic        div_busy;
    logic        div_by_zero;
    logic        div_ovf;

    typedef struct {
        logic [8:0] res;
        logic       dbz;
        logic       ovf;
        int         e0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    q_4d_share_divider dut (
        .CLK             (CLK),
        .RST             (RST),
        .dividend        (dividend),
        .dividor         (dividor),
        .division_start  (division_start),
        .signed_division (signed_division),
        .division_done   (division_done),
        .div_busy        (div_busy),
        .div_by_zero     (div_by_zero),
        .div_ovf         (div_ovf)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Independent integer reference for the scaled, saturated quotient.
    function automatic logic [10:0] model(input int a, input int b);
        longint ua, ub, m;
        logic neg;
        logic [8:0] r;
        if (b == 0) return {1'b1, 1'b0, (a >= 0) ? 9'h0FF : 9'h100};
        neg = (a < 0) != (b < 0);
        ua = (a < 0) ? -a : a;
        ub = (b < 0) ? -b : b;
`ifdef DIV_ROUND_EN
        m = (ua * 512) / ub;
        m = (m >> 1) + (m & 1);
`else
        m = (ua * 256) / ub;
`endif
        if (!neg && m > 255) return {2'b01, 9'h0FF};
        if (neg && m > 256) return {2'b01, 9'h100};
        r = 9'(neg ? -m : m);
        return {2'b00, r};
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            sb.delete();
            busy_cnt = 0;
        end else begin
            if (division_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(division_done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", 32'(signed_division), 32'(mon_e.res));
                    chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                    chk("div_ovf", 32'(div_ovf), 32'(mon_e.ovf));
                    chk("latency", 32'(cyc - mon_e.e0), 32'(LAT));
                    chk("busy_cycles", 32'(busy_cnt), 32'(LAT - 1));
                end
                busy_cnt = 0;
            end
            if (div_busy) busy_cnt++;
        end
    end

    task automatic push_exp(input logic [8:0] r, input logic dz, input logic ov, input int e0);
        exp_t e;
        e.res = r;
        e.dbz = dz;
        e.ovf = ov;
        e.e0  = e0;
        sb.push_back(e);
    endtask

    task automatic run(input int a, input int b, input logic [8:0] r, input logic dz, input logic ov);
        @(negedge CLK);
        dividend = 12'(a);
        dividor = 12'(b);
        division_start = 1'b1;
        @(posedge CLK);
        #1;
        push_exp(r, dz, ov, cyc);
        division_start = 1'b0;
        dividend = 12'($urandom);
        dividor = 12'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
        chk("done_timeout", 32'(sb.size()), 32'd0);
    endtask

    int          ta[10] = '{64, -64, -64, 2, 1, 100, -2048, -1, -5, 0};
    int          tb[10] = '{128, 128, -128, 3, 3, 3, -2048, 1, 0, 0};
    logic [8:0]  tr[10] = '{9'h080, 9'h180, 9'h080, R_2_3, 9'h055, 9'h0FF, 9'h0FF, 9'h100, 9'h100, 9'h0FF};
    logic        tz[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic        tov[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

    initial begin
        int a, b, e0;
        logic [10:0] m;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_result", 32'(signed_division), 32'd0);
        chk("rst_done", 32'(division_done), 32'd0);
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_ovf", 32'(div_ovf), 32'd0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 10; i++) begin
            run(ta[i], tb[i], tr[i], tz[i], tov[i]);
            wait_done();
        end

        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 4095)) - 2048;
            b = (i % 2 == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 16)) - 8;
            m = model(a, b);
            run(a, b, m[8:0], m[10], m[9]);
            wait_done();
        end

        // Start held high across two operations; operands change right after each capture.
        @(negedge CLK);
        dividend = 12'd64;
        dividor = 12'd128;
        division_start = 1'b1;
        @(posedge CLK);
        #1;
        e0 = cyc;
        push_exp(9'h080, 1'b0, 1'b0, e0);
        push_exp(9'h055, 1'b0, 1'b0, e0 + LAT);
        dividend = 12'd1;
        dividor = 12'd3;
        repeat (LAT) @(posedge CLK);
        #1;
        division_start = 1'b0;
        dividend = 12'hABC;
        dividor = 12'h000;
        wait_done();
        repeat (5) @(posedge CLK);

        // A start pulse in the middle of CALC must be ignored.
        run(-64, -128, 9'h080, 1'b0, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        dividend = 12'd5;
        dividor = 12'd0;
        division_start = 1'b1;
        @(posedge CLK);
        #1;
        division_start = 1'b0;
        wait_done();
        repeat (40) @(posedge CLK);

        // Reset mid-CALC clears outputs at once and produces no done pulse.
        run(-5, 0, 9'h100, 1'b1, 1'b0);
        wait_done();
        run(1, 3, 9'h055, 1'b0, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("arst_result", 32'(signed_division), 32'd0);
        chk("arst_dbz", 32'(div_by_zero), 32'd0);
        chk("arst_busy", 32'(div_busy), 32'd0);
        chk("arst_done", 32'(division_done), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (40) @(posedge CLK);

        run(64, 128, 9'h080, 1'b0, 1'b0);
        wait_done();
        repeat (5) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
